scaler_cfg_sequencer: RTL and testbench

// Runtime configuration and frame-gating controller ahead of the nearest-neighbour upscaler (clk_in1 side).

---
 rtl/scaler_cfg_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_scaler_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_cfg_sequencer.sv
// rtl/scaler_cfg_sequencer.sv - runtime config sequencer and whole-frame gate for the upscaler
//
// Purpose:
//   Accepts source/destination sizes, validates them, computes the fixed-point
//   upscale ratios floor(src*2^16/dst) with a restoring serial divider (X then Y),
//   and publishes the new geometry only while the input is in vertical blanking.
//   Input frames are forwarded whole or not at all; a frame whose vsync rises
//   with no active config is dropped and counted.
//
// Ports:
//   clk_in1, rst_n                    pixel-input clock, synchronous active-low reset
//   cfg_valid/cfg_ready               config request handshake
//   cfg_src_w/h, cfg_dst_w/h          requested sizes
//   cfg_err, cfg_applied              1-cycle pulses: rejected / active config updated
//   act_valid, act_*                  active config driven to the scaler
//   per_img_vsync/href/gray           input video
//   post_img_vsync/href/gray          gated video to the scaler (1-cycle latency)
//   drop_cnt                          saturating count of dropped frames

module scaler_cfg_sequencer #(
  parameter int C_DIM_W   = 11,
  parameter int C_RATIO_W = 16,
  parameter int C_DROP_W  = 16
) (
  input  logic                 clk_in1,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [C_DIM_W-1:0]   cfg_src_w,
  input  logic [C_DIM_W-1:0]   cfg_src_h,
  input  logic [C_DIM_W-1:0]   cfg_dst_w,
  input  logic [C_DIM_W-1:0]   cfg_dst_h,
  output logic                 cfg_err,
  output logic                 cfg_applied,
  output logic                 act_valid,
  output logic [C_DIM_W-1:0]   act_src_w,
  output logic [C_DIM_W-1:0]   act_src_h,
  output logic [C_DIM_W-1:0]   act_dst_w,
  output logic [C_DIM_W-1:0]   act_dst_h,
  output logic [C_RATIO_W-1:0] act_x_ratio,
  output logic [C_RATIO_W-1:0] act_y_ratio,
  input  logic                 per_img_vsync,
  input  logic                 per_img_href,
  input  logic [7:0]           per_img_gray,
  output logic                 post_img_vsync,
  output logic                 post_img_href,
  output logic [7:0]           post_img_gray,
  output logic [C_DROP_W-1:0]  drop_cnt
);

  localparam int CNT_W = $clog2(C_RATIO_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_RATIO_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_DIV_X,
    S_DIV_Y,
    S_PEND,
    S_APPLY
  } state_t;

  state_t state_q, state_d;

  // shadow copy of the request and its ratios, held until the apply
  logic [C_DIM_W-1:0]   sh_src_w, sh_src_h, sh_dst_w, sh_dst_h;
  logic [C_RATIO_W-1:0] sh_x_ratio, sh_y_ratio;

  // divider state
  logic [C_DIM_W:0]     rem;
  logic [C_RATIO_W-1:0] quo;
  logic [CNT_W-1:0]     cnt;

  logic                 cfg_bad;
  logic [C_DIM_W-1:0]   div_dst;
  logic [C_DIM_W+1:0]   r2;
  logic [C_DIM_W+1:0]   r2_sub;
  logic                 q_bit;
  logic [C_DIM_W:0]     rem_next;
  logic [C_RATIO_W-1:0] quo_next;
  logic                 div_last;

  // frame gate
  logic vsync_dly;
  logic gate;
  logic rise;
  logic gate_c;

  assign cfg_ready = (state_q == S_IDLE);

  // src must be strictly smaller than dst: only upscaling is supported,
  // which also keeps rem < dst so rem never needs more than C_DIM_W bits.
  assign cfg_bad = (sh_src_w == '0) || (sh_src_h == '0) ||
                   (sh_src_w >= sh_dst_w) || (sh_src_h >= sh_dst_h);

  always_comb begin
    div_dst  = (state_q == S_DIV_Y) ? sh_dst_h : sh_dst_w;
    r2       = {1'b0, rem, 1'b0};
    r2_sub   = r2 - {2'b00, div_dst};
    q_bit    = (r2 >= {2'b00, div_dst});
    rem_next = q_bit ? r2_sub[C_DIM_W:0] : r2[C_DIM_W:0];
    quo_next = {quo[C_RATIO_W-2:0], q_bit};
    div_last = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_valid) state_d = S_CHK;
      S_CHK:   state_d = cfg_bad ? S_IDLE : S_DIV_X;
      S_DIV_X: if (div_last) state_d = S_DIV_Y;
      S_DIV_Y: if (div_last) state_d = S_PEND;
      // vsync low here means the gate is already closed for the current frame
      S_PEND:  if (!per_img_vsync) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      sh_src_w    <= '0;
      sh_src_h    <= '0;
      sh_dst_w    <= '0;
      sh_dst_h    <= '0;
      sh_x_ratio  <= '0;
      sh_y_ratio  <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      cfg_err     <= 1'b0;
      cfg_applied <= 1'b0;
      act_valid   <= 1'b0;
      act_src_w   <= '0;
      act_src_h   <= '0;
      act_dst_w   <= '0;
      act_dst_h   <= '0;
      act_x_ratio <= '0;
      act_y_ratio <= '0;
    end else begin
      cfg_err     <= 1'b0;
      cfg_applied <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            sh_src_w <= cfg_src_w;
            sh_src_h <= cfg_src_h;
            sh_dst_w <= cfg_dst_w;
            sh_dst_h <= cfg_dst_h;
          end
        end
        S_CHK: begin
          if (cfg_bad) begin
            cfg_err <= 1'b1;
          end else begin
            rem <= {1'b0, sh_src_w};
            quo <= '0;
            cnt <= '0;
          end
        end
        S_DIV_X: begin
          cnt <= cnt + 1'b1;
          if (div_last) begin
            // X done: capture quotient and seed the Y divide
            sh_x_ratio <= quo_next;
            rem        <= {1'b0, sh_src_h};
            quo        <= '0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
          end
        end
        S_DIV_Y: begin
          cnt <= cnt + 1'b1;
          if (div_last) begin
            sh_y_ratio <= quo_next;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
          end
        end
        S_APPLY: begin
          act_valid   <= 1'b1;
          act_src_w   <= sh_src_w;
          act_src_h   <= sh_src_h;
          act_dst_w   <= sh_dst_w;
          act_dst_h   <= sh_dst_h;
          act_x_ratio <= sh_x_ratio;
          act_y_ratio <= sh_y_ratio;
          cfg_applied <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // act_valid is sampled only at the vsync rise, so a frame keeps the decision
  // made at its start for its whole duration.
  assign rise   = per_img_vsync & ~vsync_dly;
  assign gate_c = rise ? act_valid : (per_img_vsync & gate);

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      // vsync_dly=1 hides a rise for a frame already in flight at reset release
      vsync_dly      <= 1'b1;
      gate           <= 1'b0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_gray  <= '0;
      drop_cnt       <= '0;
    end else begin
      vsync_dly      <= per_img_vsync;
      gate           <= gate_c;
      post_img_vsync <= per_img_vsync & gate_c;
      post_img_href  <= per_img_href & per_img_vsync & gate_c;
      post_img_gray  <= per_img_gray;
      if (rise && !act_valid && (drop_cnt != {C_DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scaler_cfg_sequencer.sv
// tb/tb_scaler_cfg_sequencer.sv - randomized self-checking bench for scaler_cfg_sequencer

module tb_scaler_cfg_sequencer;

  logic        clk_in1 = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h;
  logic        cfg_err, cfg_applied;
  logic        act_valid;
  logic [10:0] act_src_w, act_src_h, act_dst_w, act_dst_h;
  logic [15:0] act_x_ratio, act_y_ratio;
  logic        per_img_vsync, per_img_href;
  logic [7:0]  per_img_gray;
  logic        post_img_vsync, post_img_href;
  logic [7:0]  post_img_gray;
  logic [15:0] drop_cnt;

  scaler_cfg_sequencer dut (
    .clk_in1        (clk_in1),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_src_w      (cfg_src_w),
    .cfg_src_h      (cfg_src_h),
    .cfg_dst_w      (cfg_dst_w),
    .cfg_dst_h      (cfg_dst_h),
    .cfg_err        (cfg_err),
    .cfg_applied    (cfg_applied),
    .act_valid      (act_valid),
    .act_src_w      (act_src_w),
    .act_src_h      (act_src_h),
    .act_dst_w      (act_dst_w),
    .act_dst_h      (act_dst_h),
    .act_x_ratio    (act_x_ratio),
    .act_y_ratio    (act_y_ratio),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_gray   (per_img_gray),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_gray  (post_img_gray),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the active configuration and drop count
  bit m_valid;
  int m_sw, m_sh, m_dw, m_dh, m_xr, m_yr, m_drop;

  // config injected in the middle of a frame
  int mc_sw, mc_sh, mc_dw, mc_dh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ratio_of(input int s, input int d);
    return (s * 65536) / d;
  endfunction

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_sw = 0; m_sh = 0; m_dw = 0; m_dh = 0;
    m_xr = 0; m_yr = 0; m_drop = 0;
  endtask

  task automatic drive_sizes(input int sw, input int sh, input int dw, input int dh);
    cfg_src_w = 11'(sw);
    cfg_src_h = 11'(sh);
    cfg_dst_w = 11'(dw);
    cfg_dst_h = 11'(dh);
  endtask

  task automatic check_act(input string tag);
    check({tag, "_valid"}, {31'd0, act_valid}, m_valid);
    check({tag, "_src_w"}, {21'd0, act_src_w}, m_sw);
    check({tag, "_src_h"}, {21'd0, act_src_h}, m_sh);
    check({tag, "_dst_w"}, {21'd0, act_dst_w}, m_dw);
    check({tag, "_dst_h"}, {21'd0, act_dst_h}, m_dh);
    check({tag, "_x_ratio"}, {16'd0, act_x_ratio}, m_xr);
    check({tag, "_y_ratio"}, {16'd0, act_y_ratio}, m_yr);
  endtask

  // Issue a config while the input is in vblank and follow it to completion.
  task automatic do_cfg(input int sw, input int sh, input int dw, input int dh);
    bit bad;
    bit done;
    int n;
    bad = (sw == 0) || (sh == 0) || (sw >= dw) || (sh >= dh);
    check("cfg_ready_idle", {31'd0, cfg_ready}, 1);
    drive_sizes(sw, sh, dw, dh);
    cfg_valid = 1'b1;
    tick();
    // scramble the request bus: the sequencer must work from its own copy
    drive_sizes($urandom, $urandom, $urandom, $urandom);
    done = 0;
    n = 0;
    while (!done && n < 60) begin
      cfg_valid = (n == 4);
      tick();
      n++;
      if (!bad && n == 10) check("cfg_ready_busy", {31'd0, cfg_ready}, 0);
      if (cfg_err || cfg_applied) done = 1;
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_timeout", 0, 1);
    if (bad) begin
      check("cfg_err_lat", n, 1);
      check("cfg_err_pulse", {31'd0, cfg_err}, 1);
      check("cfg_err_no_apply", {31'd0, cfg_applied}, 0);
      check_act("act_after_err");
      tick();
      check("cfg_ready_after_err", {31'd0, cfg_ready}, 1);
      check("cfg_err_one_cycle", {31'd0, cfg_err}, 0);
    end else begin
      check("cfg_apply_lat", n, 35);
      check("cfg_apply_ready", {31'd0, cfg_ready}, 1);
      m_valid = 1;
      m_sw = sw; m_sh = sh; m_dw = dw; m_dh = dh;
      m_xr = ratio_of(sw, dw);
      m_yr = ratio_of(sh, dh);
      check_act("act_applied");
      tick();
      check("cfg_applied_one_cycle", {31'd0, cfg_applied}, 0);
    end
  endtask

  // One input frame; the gating decision is whether a config is active at its start.
  task automatic frame(input bit mid_cfg);
    bit pass;
    bit h;
    logic [7:0] g;
    int lines, pix, total;
    pass = m_valid;
    if (!pass) m_drop = m_drop + 1;
    lines = $urandom_range(3, 5);
    pix   = $urandom_range(10, 20);
    total = lines * (pix + 3) + 4;
    for (int c = 0; c < total; c++) begin
      h = (c >= 2) && (c < total - 2) && (((c - 2) % (pix + 3)) < pix);
      g = 8'($urandom);
      per_img_vsync = 1'b1;
      per_img_href  = h;
      per_img_gray  = g;
      cfg_valid     = mid_cfg && (c == 2);
      if (mid_cfg && c == 2) drive_sizes(mc_sw, mc_sh, mc_dw, mc_dh);
      tick();
      cfg_valid = 1'b0;
      check("post_vsync", {31'd0, post_img_vsync}, pass);
      check("post_href", {31'd0, post_img_href}, h && pass);
      check("post_gray", {24'd0, post_img_gray}, g);
    end
    per_img_vsync = 1'b0;
    per_img_href  = 1'b0;
    tick();
    check("post_vsync_end", {31'd0, post_img_vsync}, 0);
    check("drop_cnt", {16'd0, drop_cnt}, m_drop);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int old_xr;
    int sw, sh, dw, dh, mode;

    rst_n = 1'b0;
    cfg_valid = 1'b0;
    drive_sizes(0, 0, 0, 0);
    per_img_vsync = 1'b0;
    per_img_href = 1'b0;
    per_img_gray = 8'd0;
    model_reset();
    gap(3);

    check("rst_act_valid", {31'd0, act_valid}, 0);
    check("rst_x_ratio", {16'd0, act_x_ratio}, 0);
    check("rst_drop", {16'd0, drop_cnt}, 0);
    check("rst_post_vsync", {31'd0, post_img_vsync}, 0);
    check("rst_cfg_err", {31'd0, cfg_err}, 0);
    check("rst_cfg_applied", {31'd0, cfg_applied}, 0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    rst_n = 1'b1;
    gap(2);

    // frames before any config are all dropped
    for (int f = 0; f < 3; f++) begin
      frame(0);
      gap(3);
    end
    check("drop_after_3", {16'd0, drop_cnt}, 3);

    do_cfg(640, 480, 1024, 768);
    check("ratio_x_640_1024", {16'd0, act_x_ratio}, 40960);
    check("ratio_y_480_768", {16'd0, act_y_ratio}, 40960);
    frame(0);
    check("drop_after_pass", {16'd0, drop_cnt}, 3);
    gap(2);

    do_cfg(100, 240, 300, 768);
    check("ratio_x_100_300", {16'd0, act_x_ratio}, 21845);
    check("ratio_y_240_768", {16'd0, act_y_ratio}, 20480);
    do_cfg(720, 480, 1280, 768);
    check("ratio_x_720_1280", {16'd0, act_x_ratio}, 36864);

    do_cfg(800, 480, 640, 768);
    do_cfg(640, 0, 1024, 768);
    check("ratio_kept_after_err", {16'd0, act_x_ratio}, 36864);

    // randomized configs mixed with frames
    for (int i = 0; i < 16; i++) begin
      dw = $urandom_range(2, 2047);
      dh = $urandom_range(2, 2047);
      mode = $urandom_range(0, 4);
      sw = (mode == 0) ? $urandom_range(dw, 2047) : $urandom_range(1, dw - 1);
      sh = (mode == 1) ? $urandom_range(dh, 2047) :
           (mode == 2) ? 0 : $urandom_range(1, dh - 1);
      do_cfg(sw, sh, dw, dh);
      if ($urandom_range(0, 1) == 1) begin
        frame(0);
        gap(2);
      end
    end

    // config arriving mid-frame is held until vblank
    do_cfg(720, 480, 1280, 768);
    old_xr = m_xr;
    mc_sw = 320; mc_sh = 240; mc_dw = 640; mc_dh = 480;
    frame(1);
    check("mid_act_held", {16'd0, act_x_ratio}, old_xr);
    check("mid_no_apply_in_frame", {31'd0, cfg_applied}, 0);
    n = 0;
    while (!cfg_applied && n < 10) begin
      tick();
      n++;
    end
    check("mid_apply_lat", n, 1);
    m_sw = mc_sw; m_sh = mc_sh; m_dw = mc_dw; m_dh = mc_dh;
    m_xr = ratio_of(mc_sw, mc_dw);
    m_yr = ratio_of(mc_sh, mc_dh);
    check("mid_ratio_x", {16'd0, act_x_ratio}, 32768);
    check_act("act_mid");
    gap(2);
    frame(0);
    gap(2);

    // reset released while a frame is in flight: that frame is blocked
    per_img_vsync = 1'b1;
    gap(3);
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    model_reset();
    check("rst_mid_act_valid", {31'd0, act_valid}, 0);
    check("rst_mid_drop", {16'd0, drop_cnt}, 0);
    for (int c = 0; c < 20; c++) begin
      per_img_href = 1'($urandom);
      tick();
      check("rst_mid_post_vsync", {31'd0, post_img_vsync}, 0);
      check("rst_mid_post_href", {31'd0, post_img_href}, 0);
    end
    per_img_vsync = 1'b0;
    per_img_href = 1'b0;
    tick();
    check("rst_mid_no_drop", {16'd0, drop_cnt}, 0);
    frame(0);
    gap(2);

    // reset in the middle of a divide leaves no active config
    drive_sizes(640, 480, 1024, 768);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    gap(8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("rst_div_act_valid", {31'd0, act_valid}, 0);
    check("rst_div_cfg_ready", {31'd0, cfg_ready}, 1);
    gap(40);
    check("rst_div_still_invalid", {31'd0, act_valid}, 0);

    do_cfg(640, 480, 1024, 768);
    frame(0);
    gap(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
